// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
//   FN_*     : opcodes understood by the 4-bit-operand / 8-bit accumulator ALU
//   state_e  : sequencer FSM states
//   INSTR_W  : program word width, {Function[1:0], Data[3:0]}
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 6;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_MUL  = 2'b01;
    localparam logic [1:0] FN_SHL  = 2'b10;
    localparam logic [1:0] FN_HOLD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/alu_seq_progmem.sv
// Program store for the ALU command sequencer.
// DEPTH x INSTR_W register file with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write slot
//   wdata_i  : word to write
//   raddr_i  : read slot
//   rdata_o  : word at raddr_i, combinational
module alu_seq_progmem
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command initiator for the 4-bit-operand / 8-bit registered accumulator ALU.
// Replays a stored program of {Function, Data} commands into the ALU, one per
// cycle, after clearing the accumulator; then captures the final ALUout and
// compares it to an expected value.
//   Clock, Reset_b        : clock (rising edge), async active-low reset
//   Load/LoadAddr/LoadInstr : program write (accepted in IDLE only)
//   Length, Expected      : run length and expected result, sampled on Start
//   Start, Abort          : begin / cancel a run
//   ALUout                : accumulator value read back from the ALU
//   Data, Function        : registered command to the ALU
//   Busy, Done            : run in progress / one-cycle completion pulse
//   Result, Pass          : captured final ALUout and compare outcome
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic               Clock,
    input  logic               Reset_b,
    input  logic               Load,
    input  logic [AW-1:0]      LoadAddr,
    input  logic [INSTR_W-1:0] LoadInstr,
    input  logic [AW:0]        Length,
    input  logic [7:0]         Expected,
    input  logic               Start,
    input  logic               Abort,
    input  logic [7:0]         ALUout,
    output logic [3:0]         Data,
    output logic [1:0]         Function,
    output logic               Busy,
    output logic               Done,
    output logic [7:0]         Result,
    output logic               Pass
);

    localparam logic [AW:0] LEN_MAX = DEPTH[AW:0];

    state_e             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [7:0]         exp_q, exp_d;
    logic [1:0]         fn_q, fn_d;
    logic [3:0]         data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         result_q, result_d;
    logic               pass_q, pass_d;
    logic [INSTR_W-1:0] prog_rdata;
    logic               prog_we;

    // A write in the Start cycle lands before CLEAR reads slot 0.
    assign prog_we = Load && (state_q == S_IDLE);

    alu_seq_progmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_progmem (
        .clk_i   (Clock),
        .we_i    (prog_we),
        .waddr_i (LoadAddr),
        .wdata_i (LoadInstr),
        .raddr_i (pc_q),
        .rdata_o (prog_rdata)
    );

    // Next-state logic computes the command for the *next* cycle so that all
    // outputs come straight from flops.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        fn_d     = FN_HOLD;
        data_d   = 4'h0;
        done_d   = 1'b0;
        result_d = result_q;
        pass_d   = pass_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_CLEAR;
                    pc_d    = '0;
                    cnt_d   = (Length > LEN_MAX) ? LEN_MAX : Length;
                    exp_d   = Expected;
                    // Multiply by zero empties the accumulator.
                    fn_d    = FN_MUL;
                    data_d  = 4'h0;
                end
            end
            S_CLEAR, S_RUN: begin
                // cnt_q counts commands still to issue.
                if (cnt_q != '0) begin
                    state_d         = S_RUN;
                    {fn_d, data_d}  = prog_rdata;
                    pc_d            = pc_q + 1'b1;
                    cnt_d           = cnt_q - 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // ALUout now holds the effect of the last command.
                state_d  = S_IDLE;
                pc_d     = '0;
                result_d = ALUout;
                pass_d   = (ALUout == exp_q);
                done_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        if (Abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            pc_d     = '0;
            cnt_d    = '0;
            fn_d     = FN_HOLD;
            data_d   = 4'h0;
            done_d   = 1'b0;
            result_d = result_q;
            pass_d   = pass_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            exp_q    <= 8'h00;
            fn_q     <= FN_HOLD;
            data_q   <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            fn_q     <= fn_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            pass_q   <= pass_d;
        end
    end

    assign Data     = data_q;
    assign Function = fn_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign Pass     = pass_q;

endmodule
